// File: rtl/fight_referee.sv
// fight_referee: match controller that paces steps, latches actions, judges rounds and the match
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   start                  begin a match (honoured only in IDLE or MATCH_END)
//   action1_in/action2_in  raw player action codes
//   health1/health2        player health, 0 means KO
//   step                   one-cycle game-step strobe (FIGHT only)
//   action1/action2        latched actions shown to the players (await outside FIGHT)
//   round_rst              one-cycle pulse at the start of every countdown
//   phase                  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_END
//   time_left, round_num   steps left in the round, rounds started in the match
//   wins1/wins2            round wins per player
//   round_over/match_over  phase flags for ROUND_END / MATCH_END
//   winner                 00 none, 01 P1, 10 P2, 11 draw
module fight_referee #(
    parameter int TICK_DIV        = 4,
    parameter int COUNTDOWN_STEPS = 3,
    parameter int ROUND_STEPS     = 20,
    parameter int ROUNDS_TO_WIN   = 2,
    parameter int MAX_ROUNDS      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] action1_in,
    input  logic [2:0] action2_in,
    input  logic [1:0] health1,
    input  logic [1:0] health2,
    output logic       step,
    output logic [2:0] action1,
    output logic [2:0] action2,
    output logic       round_rst,
    output logic [2:0] phase,
    output logic [4:0] time_left,
    output logic [2:0] round_num,
    output logic [1:0] wins1,
    output logic [1:0] wins2,
    output logic       round_over,
    output logic       match_over,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        FIGHT     = 3'd2,
        ROUND_END = 3'd3,
        MATCH_END = 3'd4
    } phase_t;

    localparam logic [3:0] DIV_LAST = 4'(TICK_DIV - 1);
    localparam logic [3:0] DIV_CAP  = 4'(TICK_DIV - 2);
    localparam logic [3:0] CD_LAST  = 4'(COUNTDOWN_STEPS - 1);
    localparam logic [4:0] T_LOAD   = 5'(ROUND_STEPS);
    localparam logic [1:0] WIN_MAX  = 2'(ROUNDS_TO_WIN);
    localparam logic [2:0] R_MAX    = 3'(MAX_ROUNDS);
    localparam logic [2:0] AWAIT    = 3'b010;

    phase_t     phase_q, phase_d;
    logic [3:0] div_q, div_d, cd_q, cd_d;
    logic [4:0] time_q, time_d;
    logic [2:0] round_q, round_d, act1_q, act1_d, act2_q, act2_d;
    logic [1:0] wins1_q, wins1_d, wins2_q, wins2_d, winner_q, winner_d, res;
    logic       eval_q, eval_d, rr_q, rr_d;

    assign step = (phase_q == FIGHT) && (div_q == DIV_LAST);

    // Round verdict from the health seen in the eval cycle; KO outranks timeout, 00 = keep fighting
    assign res = (health1 == 2'd0 && health2 == 2'd0) ? 2'b11 :
                 (health2 == 2'd0)                    ? 2'b01 :
                 (health1 == 2'd0)                    ? 2'b10 :
                 (time_q != 5'd0)                     ? 2'b00 :
                 (health1 > health2)                  ? 2'b01 :
                 (health2 > health1)                  ? 2'b10 : 2'b11;

    always_comb begin
        phase_d  = phase_q;
        cd_d     = cd_q;
        time_d   = time_q;
        round_d  = round_q;
        wins1_d  = wins1_q;
        wins2_d  = wins2_q;
        winner_d = winner_q;
        eval_d   = 1'b0;
        rr_d     = 1'b0;
        case (phase_q)
            IDLE, MATCH_END: begin
                if (start) begin
                    phase_d  = COUNTDOWN;
                    round_d  = 3'd1;
                    wins1_d  = 2'd0;
                    wins2_d  = 2'd0;
                    time_d   = T_LOAD;
                    winner_d = 2'b00;
                    cd_d     = 4'd0;
                    rr_d     = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (div_q == DIV_LAST) begin
                    if (cd_q == CD_LAST) phase_d = FIGHT;
                    else cd_d = cd_q + 4'd1;
                end
            end
            FIGHT: begin
                if (step) begin
                    time_d = (time_q == 5'd0) ? 5'd0 : time_q - 5'd1;
                    eval_d = 1'b1;
                end
                if (eval_q && res != 2'b00) begin
                    phase_d  = ROUND_END;
                    winner_d = res;
                    wins1_d  = wins1_q + {1'b0, res == 2'b01};
                    wins2_d  = wins2_q + {1'b0, res == 2'b10};
                end
            end
            ROUND_END: begin
                if (div_q == DIV_LAST) begin
                    if (wins1_q == WIN_MAX || wins2_q == WIN_MAX || round_q == R_MAX) begin
                        phase_d  = MATCH_END;
                        winner_d = (wins1_q > wins2_q) ? 2'b01 : (wins2_q > wins1_q) ? 2'b10 : 2'b11;
                    end else begin
                        phase_d  = COUNTDOWN;
                        round_d  = round_q + 3'd1;
                        time_d   = T_LOAD;
                        winner_d = 2'b00;
                        cd_d     = 4'd0;
                        rr_d     = 1'b1;
                    end
                end
            end
            default: phase_d = IDLE;
        endcase
        // The divider only runs inside a timed phase and restarts on every phase change
        div_d  = ((phase_q inside {COUNTDOWN, FIGHT, ROUND_END}) && phase_d == phase_q && div_q != DIV_LAST)
                 ? div_q + 4'd1 : 4'd0;
        act1_d = (phase_d != FIGHT) ? AWAIT : (div_q == DIV_CAP) ? action1_in : act1_q;
        act2_d = (phase_d != FIGHT) ? AWAIT : (div_q == DIV_CAP) ? action2_in : act2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= IDLE;
            div_q    <= 4'd0;
            cd_q     <= 4'd0;
            time_q   <= 5'd0;
            round_q  <= 3'd0;
            wins1_q  <= 2'd0;
            wins2_q  <= 2'd0;
            winner_q <= 2'b00;
            eval_q   <= 1'b0;
            rr_q     <= 1'b0;
            act1_q   <= AWAIT;
            act2_q   <= AWAIT;
        end else begin
            phase_q  <= phase_d;
            div_q    <= div_d;
            cd_q     <= cd_d;
            time_q   <= time_d;
            round_q  <= round_d;
            wins1_q  <= wins1_d;
            wins2_q  <= wins2_d;
            winner_q <= winner_d;
            eval_q   <= eval_d;
            rr_q     <= rr_d;
            act1_q   <= act1_d;
            act2_q   <= act2_d;
        end
    end

    assign action1    = act1_q;
    assign action2    = act2_q;
    assign round_rst  = rr_q;
    assign phase      = phase_q;
    assign time_left  = time_q;
    assign round_num  = round_q;
    assign wins1      = wins1_q;
    assign wins2      = wins2_q;
    assign round_over = (phase_q == ROUND_END);
    assign match_over = (phase_q == MATCH_END);
    assign winner     = winner_q;
endmodule

// File: tb/tb_fight_referee.sv
// tb_fight_referee: directed + randomized check of fight_referee against a cycle-count reference model
module tb_fight_referee;
    localparam int TD = 2, CS = 1, RS = 4, RTW = 2, MR = 3;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [2:0] action1_in, action2_in;
    logic [1:0] health1, health2;
    logic       step, round_rst, round_over, match_over;
    logic [2:0] action1, action2, phase, round_num;
    logic [4:0] time_left;
    logic [1:0] wins1, wins2, winner;

    int total = 0, bad = 0;
    logic go = 1'b0, noise = 1'b0;
    logic [2:0] last_a1;

    // Reference model: phase plus cycles elapsed in that phase, match-level tallies
    int m_ph = 0, m_t = 0, m_rounds = 0, m_w1 = 0, m_w2 = 0, m_tl = 0, m_win = 0;
    logic m_rr = 1'b0;
    logic [2:0] m_a1 = 3'b010, m_a2 = 3'b010;

    fight_referee #(.TICK_DIV(TD), .COUNTDOWN_STEPS(CS), .ROUND_STEPS(RS),
                    .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .action1_in(action1_in), .action2_in(action2_in),
        .health1(health1), .health2(health2),
        .step(step), .action1(action1), .action2(action2), .round_rst(round_rst),
        .phase(phase), .time_left(time_left), .round_num(round_num),
        .wins1(wins1), .wins2(wins2), .round_over(round_over),
        .match_over(match_over), .winner(winner)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int verdict();
        if (health1 == 0 && health2 == 0) return 3;
        if (health2 == 0) return 1;
        if (health1 == 0) return 2;
        if (m_tl != 0) return 0;
        if (health1 > health2) return 1;
        if (health2 > health1) return 2;
        return 3;
    endfunction

    task automatic begin_round();
        m_ph = 1; m_t = 0; m_tl = RS; m_win = 0; m_rr = 1'b1;
    endtask

    task automatic model_edge();
        int v;
        m_rr = 1'b0;
        if (!rst_n) begin
            m_ph = 0; m_t = 0; m_rounds = 0; m_w1 = 0; m_w2 = 0; m_tl = 0; m_win = 0;
            m_a1 = 3'b010; m_a2 = 3'b010;
            return;
        end
        case (m_ph)
            0, 4: if (start) begin m_w1 = 0; m_w2 = 0; m_rounds = 1; begin_round(); end
            1: if (m_t + 1 == CS * TD) begin m_ph = 2; m_t = 0; end else m_t++;
            2: begin
                v = (m_t > 0 && m_t % TD == 0) ? verdict() : 0;
                if (m_t % TD == TD - 1 && m_tl > 0) m_tl--;
                if (v != 0) begin
                    m_ph = 3; m_t = 0; m_win = v;
                    if (v == 1) m_w1++;
                    if (v == 2) m_w2++;
                end else begin
                    if (m_t % TD == TD - 2) begin m_a1 = action1_in; m_a2 = action2_in; end
                    m_t++;
                end
            end
            3: if (m_t + 1 == TD) begin
                if (m_w1 == RTW || m_w2 == RTW || m_rounds == MR) begin
                    m_ph = 4;
                    m_win = (m_w1 > m_w2) ? 1 : (m_w2 > m_w1) ? 2 : 3;
                end else begin
                    m_rounds++;
                    begin_round();
                end
            end else m_t++;
            default: m_ph = 0;
        endcase
        if (m_ph != 2) begin m_a1 = 3'b010; m_a2 = 3'b010; end
    endtask

    task automatic cycle();
        logic [26:0] exp_v, got_v;
        action1_in = 3'($urandom);
        action2_in = 3'($urandom);
        last_a1 = action1_in;
        start = go | (noise && m_ph >= 1 && m_ph <= 3 && $urandom_range(0, 3) == 0);
        model_edge();
        @(posedge clk);
        #1;
        exp_v = {3'(m_ph), m_ph == 2 && m_t % TD == TD - 1, m_rr, m_a1, m_a2, 5'(m_tl),
                 3'(m_rounds), 2'(m_w1), 2'(m_w2), m_ph == 3, m_ph == 4, 2'(m_win)};
        got_v = {phase, step, round_rst, action1, action2, time_left, round_num,
                 wins1, wins2, round_over, match_over, winner};
        check("cycle", 32'(got_v), 32'(exp_v));
    endtask

    task automatic run_until_phase(input logic [2:0] p, input int budget);
        int n = 0;
        while (phase !== p && n < budget) begin cycle(); n++; end
        check("phase_wait", 32'(phase), 32'(p));
    endtask

    initial begin
        int n;
        logic [1:0] h;
        rst_n = 1'b0; start = 1'b0; health1 = 2'd3; health2 = 2'd3;
        action1_in = 3'd0; action2_in = 3'd0;
        cycle(); cycle();
        check("rst_phase", 32'(phase), 0);
        check("rst_step", 32'(step), 0);
        check("rst_act1", 32'(action1), 32'h2);
        check("rst_act2", 32'(action2), 32'h2);
        check("rst_counters", 32'({time_left, round_num, wins1, wins2, round_rst}), 0);
        check("rst_winner", 32'(winner), 0);
        rst_n = 1'b1;
        cycle();
        go = 1'b1; cycle(); go = 1'b0;
        check("start_rr", 32'(round_rst), 1);
        check("start_phase", 32'(phase), 1);
        check("start_round", 32'(round_num), 1);
        check("start_time", 32'(time_left), 4);
        cycle();
        check("rr_once", 32'(round_rst), 0);
        cycle();
        check("fight_entry", 32'(phase), 2);
        noise = 1'b1;
        cycle();
        check("step1", 32'(step), 1);
        check("act_capture", 32'(action1), 32'(last_a1));
        health2 = 2'd0;
        cycle();
        check("eval_phase", 32'(phase), 2);
        cycle();
        check("ko_phase", 32'(phase), 3);
        check("ko_winner", 32'(winner), 1);
        check("ko_wins1", 32'(wins1), 1);
        health2 = 2'd3;
        cycle();
        check("round_over_hold", 32'(round_over), 1);
        cycle();
        check("re_countdown", 32'(phase), 1);
        check("re_round_rst", 32'(round_rst), 1);
        health1 = 2'd2; health2 = 2'd1;
        run_until_phase(3'd3, 40);
        check("timeout_time", 32'(time_left), 0);
        check("timeout_winner", 32'(winner), 1);
        check("timeout_wins1", 32'(wins1), 2);
        run_until_phase(3'd4, 10);
        check("match_over", 32'(match_over), 1);
        check("match_winner", 32'(winner), 1);
        noise = 1'b0;
        repeat (3) cycle();
        check("match_hold", 32'(phase), 4);
        go = 1'b1; cycle(); go = 1'b0;
        check("restart_wins", 32'({wins1, wins2}), 0);
        check("restart_round", 32'(round_num), 1);
        check("restart_phase", 32'(phase), 1);
        noise = 1'b1;
        health1 = 2'd3; health2 = 2'd3;
        run_until_phase(3'd3, 40);
        check("tie_winner", 32'(winner), 3);
        check("tie_wins", 32'({wins1, wins2}), 0);
        health1 = 2'd1; health2 = 2'd3;
        n = 0;
        while (!(step === 1'b1 && time_left == 5'd1) && n < 60) begin cycle(); n++; end
        check("step4_wait", 32'({step, time_left}), 32'h21);
        health2 = 2'd0;
        cycle();
        check("last_step_time", 32'(time_left), 0);
        cycle();
        check("ko_beats_timeout", 32'(winner), 1);
        health1 = 2'd0; health2 = 2'd3;
        run_until_phase(3'd1, 10);
        run_until_phase(3'd3, 40);
        check("p2_ko_winner", 32'(winner), 2);
        run_until_phase(3'd4, 10);
        check("cap_round", 32'(round_num), 3);
        check("cap_winner", 32'(winner), 3);
        noise = 1'b0;
        go = 1'b1; cycle(); go = 1'b0;
        noise = 1'b1;
        health1 = 2'd0; health2 = 2'd0;
        run_until_phase(3'd3, 40);
        check("double_ko", 32'(winner), 3);
        health1 = 2'd2; health2 = 2'd2;
        run_until_phase(3'd1, 10);
        run_until_phase(3'd3, 40);
        h = 2'($urandom_range(1, 3));
        health1 = h; health2 = h;
        run_until_phase(3'd1, 10);
        run_until_phase(3'd3, 40);
        run_until_phase(3'd4, 10);
        check("draw_cap_winner", 32'(winner), 3);
        check("draw_cap_rounds", 32'({round_num, wins1, wins2}), 32'h30);
        repeat (6) begin
            noise = 1'b0;
            go = 1'b1; cycle(); go = 1'b0;
            noise = 1'b1;
            n = 0;
            while (phase !== 3'd4 && n < 300) begin
                if (round_rst) begin
                    health1 = 2'($urandom_range(0, 3));
                    health2 = 2'($urandom_range(0, 3));
                end
                cycle();
                n++;
            end
            check("rand_match_end", 32'(phase), 4);
        end
        noise = 1'b0;
        health1 = 2'd3; health2 = 2'd3;
        go = 1'b1; cycle(); go = 1'b0;
        run_until_phase(3'd2, 10);
        cycle(); cycle();
        rst_n = 1'b0;
        cycle();
        check("midfight_rst_phase", 32'(phase), 0);
        check("midfight_rst_outs", 32'({step, round_rst, time_left, round_num, wins1, wins2, winner}), 0);
        check("midfight_rst_acts", 32'({action1, action2}), 32'o22);
        rst_n = 1'b1;
        cycle();
        check("idle_after_rst", 32'(phase), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
